// File: rtl/mac_rx_pkg.sv
// Shared types for the MAC receive read controller: FSM states, descriptor layout
// and word size. Descriptor address is carried as 16 bits; the top uses ADDR_W of them.
package mac_rx_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DROP
  } rx_state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] len;
  } rx_desc_t;

endpackage

// File: rtl/mac_rx_desc_fifo.sv
// Descriptor FIFO with a registered head: an entry pushed at one edge becomes
// visible on valid_o one edge later. DEPTH counts all entries, head included.
module mac_rx_desc_fifo
  import mac_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     push_i,
  input  rx_desc_t push_data_i,
  input  logic     pop_i,
  output logic     valid_o,
  output rx_desc_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  rx_desc_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   mem_cnt_q;
  logic [PTR_W:0]   total;
  logic             valid_q;
  rx_desc_t         data_q;
  logic             pop;
  logic             push_ok;
  logic             load;

  assign pop     = pop_i & valid_q;
  assign total   = mem_cnt_q + {{PTR_W{1'b0}}, valid_q};
  assign full_o  = (total == DEPTH_C);
  assign empty_o = (total == '0);
  // A pop at the same edge frees the slot a full FIFO needs for the push.
  assign push_ok = push_i & (~full_o | pop);
  assign load    = (~valid_q | pop) & (mem_cnt_q != '0);
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        data_q   <= mem_q[rd_ptr_q];
        valid_q  <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      mem_cnt_q <= mem_cnt_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, load};
    end
  end

endmodule

// File: rtl/mac_rx_read_ctrl.sv
// Pulls frames from the tri-mode MAC client into the packet RAM ring and queues
// one descriptor per good frame. Define MAC_RX_STATS_EN for packet/byte/drop counters.
module mac_rx_read_ctrl
  import mac_rx_pkg::*;
#(
  parameter int ADDR_W        = 12,
  parameter int MAX_PKT_WORDS = 512,
  parameter int DESC_DEPTH    = 8
) (
  input  logic              mac_clk_i,
  input  logic              mac_rst_n_i,
  input  logic [31:0]       mac_rxd_i,
  input  logic [1:0]        mac_ben_i,
  input  logic              mac_rxda_i,
  input  logic              mac_rxsop_i,
  input  logic              mac_rxeop_i,
  input  logic              mac_rxdv_i,
  output logic              mac_rxrqrd_o,
  input  logic              enable_i,
  output logic              buf_we_o,
  output logic [ADDR_W-1:0] buf_waddr_o,
  output logic [31:0]       buf_wdata_o,
  input  logic [ADDR_W:0]   buf_rd_ptr_i,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [ADDR_W-1:0] desc_addr_o,
  output logic [15:0]       desc_len_o
`ifdef MAC_RX_STATS_EN
  ,
  output logic [31:0]       stat_pkt_cnt_o,
  output logic [31:0]       stat_byte_cnt_o,
  output logic [15:0]       stat_drop_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);
  localparam logic [ADDR_W:0] RING_WORDS = (ADDR_W + 1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] MAX_WORDS  = (ADDR_W + 1)'(MAX_PKT_WORDS);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PKT_WORDS);

  rx_state_e         state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   start_ptr_q, start_ptr_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              rqrd_q, rqrd_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [ADDR_W:0]   used;
  logic [ADDR_W:0]   free;
  logic [ADDR_W:0]   capture_base;
  logic              can_start;
  logic              push;
  rx_desc_t          push_desc;
  logic              drop_evt;
  logic              fifo_full;
  logic              fifo_empty;
  rx_desc_t          fifo_head;
  logic              unused_ok;

  assign used      = wr_ptr_q - buf_rd_ptr_i;
  assign free      = RING_WORDS - used;
  assign can_start = enable_i & mac_rxda_i & (free >= MAX_WORDS) & ~fifo_full;
  // A SOP seen mid-frame restarts capture at the aborted frame's start.
  assign capture_base = (state_q == DATA) ? start_ptr_q : wr_ptr_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    start_ptr_d = start_ptr_q;
    word_cnt_d  = word_cnt_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    push        = 1'b0;
    push_desc   = '0;
    drop_evt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d = REQ;
        end
      end
      REQ, DATA: begin
        if (mac_rxdv_i && mac_rxsop_i) begin
          we_d        = 1'b1;
          waddr_d     = capture_base[ADDR_W-1:0];
          wdata_d     = mac_rxd_i;
          wr_ptr_d    = capture_base + (ADDR_W + 1)'(1);
          start_ptr_d = capture_base;
          word_cnt_d  = CNT_W'(1);
          drop_evt    = (state_q == DATA);
          if (mac_rxeop_i) begin
            push           = 1'b1;
            push_desc.addr = 16'(capture_base[ADDR_W-1:0]);
            push_desc.len  = 16'(mac_ben_i) + 16'd1;
            state_d        = IDLE;
          end else begin
            state_d = DATA;
          end
        end else if (mac_rxdv_i && (state_q == DATA)) begin
          if (word_cnt_q == MAX_CNT) begin
            wr_ptr_d = start_ptr_q;
            drop_evt = 1'b1;
            // An oversize word that is also EOP has nothing left to drain.
            state_d  = mac_rxeop_i ? IDLE : DROP;
          end else begin
            we_d       = 1'b1;
            waddr_d    = wr_ptr_q[ADDR_W-1:0];
            wdata_d    = mac_rxd_i;
            wr_ptr_d   = wr_ptr_q + (ADDR_W + 1)'(1);
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (mac_rxeop_i) begin
              push           = 1'b1;
              push_desc.addr = 16'(start_ptr_q[ADDR_W-1:0]);
              push_desc.len  = 16'(word_cnt_q) * 16'(BYTES_PER_WORD)
                             + 16'(mac_ben_i) + 16'd1;
              state_d        = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (mac_rxdv_i && mac_rxeop_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    rqrd_d = (state_d != IDLE);
  end

  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      start_ptr_q <= '0;
      word_cnt_q  <= '0;
      rqrd_q      <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      start_ptr_q <= start_ptr_d;
      word_cnt_q  <= word_cnt_d;
      rqrd_q      <= rqrd_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  mac_rx_desc_fifo #(
    .DEPTH(DESC_DEPTH)
  ) u_desc_fifo (
    .clk_i      (mac_clk_i),
    .rst_n_i    (mac_rst_n_i),
    .push_i     (push),
    .push_data_i(push_desc),
    .pop_i      (desc_ready_i),
    .valid_o    (desc_valid_o),
    .data_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign mac_rxrqrd_o = rqrd_q;
  assign buf_we_o     = we_q;
  assign buf_waddr_o  = waddr_q;
  assign buf_wdata_o  = wdata_q;
  assign desc_addr_o  = fifo_head.addr[ADDR_W-1:0];
  assign desc_len_o   = fifo_head.len;
  assign unused_ok    = &{1'b0, fifo_empty, fifo_head};

`ifdef MAC_RX_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] byte_cnt_q;
  logic [15:0] drop_cnt_q;
  logic [32:0] byte_sum;

  assign byte_sum = {1'b0, byte_cnt_q} + {17'd0, push_desc.len};

  always_ff @(posedge mac_clk_i or negedge mac_rst_n_i) begin
    if (!mac_rst_n_i) begin
      pkt_cnt_q  <= '0;
      byte_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push && (pkt_cnt_q != '1)) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (push) begin
        byte_cnt_q <= byte_sum[32] ? '1 : byte_sum[31:0];
      end
      if (drop_evt && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign stat_pkt_cnt_o  = pkt_cnt_q;
  assign stat_byte_cnt_o = byte_cnt_q;
  assign stat_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mac_rx_read_ctrl.sv
// Directed and randomized frames against a frame-level model of the ring writer
// and descriptor queue (ADDR_W=12, MAX_PKT_WORDS=512, DESC_DEPTH=8).
module tb_mac_rx_read_ctrl;

  localparam int AW   = 12;
  localparam int MAXW = 512;
  localparam int RING = 4096;
  localparam int PMOD = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rxd;
  logic [1:0]  ben;
  logic        rxda, sop, eop, dv, en, ready;
  logic [AW:0] rd_ptr;
  logic        rqrd, we, dvalid;
  logic [AW-1:0] waddr, daddr;
  logic [31:0] wdata;
  logic [15:0] dlen;
`ifdef MAC_RX_STATS_EN
  logic [31:0] st_pkt, st_byte;
  logic [15:0] st_drop;
`endif

  int checks = 0;
  int errors = 0;
  int m_wr = 0;
  int m_pkts = 0;
  int m_bytes = 0;
  int m_drops = 0;
  int exp_addr_q[$];
  int exp_len_q[$];
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  mac_rx_read_ctrl dut (
    .mac_clk_i   (clk),
    .mac_rst_n_i (rst_n),
    .mac_rxd_i   (rxd),
    .mac_ben_i   (ben),
    .mac_rxda_i  (rxda),
    .mac_rxsop_i (sop),
    .mac_rxeop_i (eop),
    .mac_rxdv_i  (dv),
    .mac_rxrqrd_o(rqrd),
    .enable_i    (en),
    .buf_we_o    (we),
    .buf_waddr_o (waddr),
    .buf_wdata_o (wdata),
    .buf_rd_ptr_i(rd_ptr),
    .desc_valid_o(dvalid),
    .desc_ready_i(ready),
    .desc_addr_o (daddr),
    .desc_len_o  (dlen)
`ifdef MAC_RX_STATS_EN
    ,
    .stat_pkt_cnt_o (st_pkt),
    .stat_byte_cnt_o(st_byte),
    .stat_drop_cnt_o(st_drop)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: a pending handshake is scored before the edge, the write port after it.
  task automatic tick(input bit e_we, input int e_addr, input logic [31:0] e_data);
    if (rand_ready) ready = 1'($urandom_range(0, 1));
    if (dvalid === 1'b1 && ready === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        chk("desc_unexpected", 64'd1, 64'd0);
      end else begin
        chk("desc_addr", 64'(daddr), 64'(exp_addr_q.pop_front()));
        chk("desc_len", 64'(dlen), 64'(exp_len_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    chk("buf_we", 64'(we), 64'(e_we));
    if (e_we) begin
      chk("buf_waddr", 64'(waddr), 64'(e_addr));
      chk("buf_wdata", 64'(wdata), 64'(e_data));
    end
  endtask

  task automatic idle();
    dv = 1'b0; sop = 1'b0; eop = 1'b0;
    tick(1'b0, 0, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 64 && rqrd !== 1'b1; i++) idle();
    chk(tag, 64'(rqrd), 64'd1);
  endtask

  task automatic hold_off(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      idle();
      chk(tag, 64'(rqrd), 64'd0);
    end
  endtask

  // Frame model: words land at consecutive ring addresses from the write pointer;
  // only the first MAXW are written; only complete frames within MAXW advance it.
  task automatic send_frame(input int n, input int b, input bit do_eop,
                            input int gap_at, input int gap_len, input bit rand_stall);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) repeat (gap_len) idle();
      if (rand_stall && i > 0 && $urandom_range(0, 3) == 0) idle();
      d   = $urandom;
      rxd = d;
      dv  = 1'b1;
      sop = (i == 0);
      eop = do_eop && (i == n - 1);
      ben = eop ? 2'(b) : 2'($urandom_range(0, 3));
      tick(i < MAXW, (m_wr + i) % RING, d);
    end
    dv = 1'b0; sop = 1'b0; eop = 1'b0;
    if (do_eop) begin
      chk("rqrd_after_eop", 64'(rqrd), 64'd0);
      if (n <= MAXW) begin
        exp_addr_q.push_back(m_wr % RING);
        exp_len_q.push_back((n - 1) * 4 + b + 1);
        m_pkts++;
        m_bytes += (n - 1) * 4 + b + 1;
        m_wr = (m_wr + n) % PMOD;
      end else begin
        m_drops++;
      end
    end else begin
      m_drops++;
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 64 && exp_addr_q.size() > 0; i++) idle();
    chk("drain_left", 64'(exp_addr_q.size()), 64'd0);
    chk("desc_valid_drained", 64'(dvalid), 64'd0);
  endtask

`ifdef MAC_RX_STATS_EN
  task automatic chk_stats();
    chk("stat_pkt", 64'(st_pkt), 64'(m_pkts));
    chk("stat_byte", 64'(st_byte), 64'(m_bytes));
    chk("stat_drop", 64'(st_drop), 64'(m_drops));
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; rxd = '0; ben = '0; rxda = 1'b0; sop = 1'b0; eop = 1'b0;
    dv = 1'b0; en = 1'b0; ready = 1'b1; rd_ptr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rqrd", 64'(rqrd), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_dvalid", 64'(dvalid), 64'd0);
    chk("rst_daddr", 64'(daddr), 64'd0);
    chk("rst_dlen", 64'(dlen), 64'd0);
    rst_n = 1'b1;
    rxda = 1'b1;
    hold_off(4, "rqrd_disabled");
    en = 1'b1;

    wait_req("req_4w");
    send_frame(4, 1, 1'b1, -1, 0, 1'b0);
    wait_req("req_1w");
    send_frame(1, 3, 1'b1, -1, 0, 1'b0);
    wait_req("req_gap");
    send_frame(6, 2, 1'b1, 3, 5, 1'b0);
    wait_req("req_abort");
    send_frame(3, 0, 1'b0, -1, 0, 1'b0);
    send_frame(4, 0, 1'b1, -1, 0, 1'b0);
    wait_req("req_max");
    send_frame(MAXW, 3, 1'b1, -1, 0, 1'b0);
    wait_req("req_oversize");
    send_frame(520, 0, 1'b1, -1, 0, 1'b0);
`ifdef MAC_RX_STATS_EN
    chk_stats();
`endif

    rd_ptr = (AW + 1)'((m_wr + PMOD - (RING - (MAXW - 1))) % PMOD);
    hold_off(20, "rqrd_ring_full");
    rd_ptr = rd_ptr + 1'b1;
    wait_req("req_ring_freed");
    send_frame(3, 2, 1'b1, -1, 0, 1'b0);
    rd_ptr = (AW + 1)'(m_wr);

    drain();
    ready = 1'b0;
    for (int f = 0; f < 8; f++) begin
      wait_req("req_fill");
      send_frame($urandom_range(1, 6), $urandom_range(0, 3), 1'b1, -1, 0, 1'b1);
    end
    chk("desc_valid_full", 64'(dvalid), 64'd1);
    hold_off(20, "rqrd_fifo_full");
    ready = 1'b1;
    idle();
    ready = 1'b0;
    wait_req("req_after_pop");
    send_frame(5, 1, 1'b1, -1, 0, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int f = 0; f < 12; f++) begin
      n = $urandom_range(1, 24);
      wait_req("req_rand");
      if ($urandom_range(0, 4) == 0)
        send_frame($urandom_range(1, 5), 0, 1'b0, -1, 0, 1'b1);
      send_frame(n, $urandom_range(0, 3), 1'b1, -1, 0, 1'b1);
    end
    drain();
`ifdef MAC_RX_STATS_EN
    chk_stats();
`endif

    ready = 1'b0;
    wait_req("req_pre_rst");
    send_frame(2, 0, 1'b1, -1, 0, 1'b0);
    wait_req("req_partial");
    send_frame(3, 0, 1'b0, -1, 0, 1'b0);
    chk("desc_valid_pre_rst", 64'(dvalid), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("midrst_dvalid", 64'(dvalid), 64'd0);
    chk("midrst_we", 64'(we), 64'd0);
    chk("midrst_rqrd", 64'(rqrd), 64'd0);
    exp_addr_q.delete();
    exp_len_q.delete();
    m_wr = 0; m_pkts = 0; m_bytes = 0; m_drops = 0;
    rd_ptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    wait_req("req_post_rst");
    send_frame(2, 1, 1'b1, -1, 0, 1'b0);
    drain();
`ifdef MAC_RX_STATS_EN
    chk_stats();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
